// File: rtl/mem_port_arbiter_if.sv
// Bundle between the CPU requesters, the shared single-port memory and the arbiter.
// The arbiter takes the slave view; the core/memory side takes the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_addr, mem_wdata, mem_we, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and data access; one access per two cycles, registered read data and ack pulse.
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int RR_INIT = 0
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  typedef enum logic {IDLE, ACK} state_e;

  state_e            state_q, state_d;
  logic              prio_q, prio_d;   // 0: IF wins contention, 1: DM wins
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              grant_if, grant_dm;

  always_comb begin
    grant_if = 1'b0;
    grant_dm = 1'b0;
    if (state_q == IDLE) begin
      grant_if = bus.if_req && (!bus.dm_req || !prio_q);
      grant_dm = bus.dm_req && (!bus.if_req ||  prio_q);
    end
  end

  always_comb begin
    state_d       = IDLE;
    prio_d        = prio_q;
    if_ack_d      = 1'b0;
    dm_ack_d      = 1'b0;
    if_rdata_d    = if_rdata_q;
    dm_rdata_d    = dm_rdata_q;
    bus.mem_addr  = {ADDR_W{1'b0}};
    bus.mem_wdata = {DATA_W{1'b0}};
    bus.mem_we    = 1'b0;
    if (grant_if) begin
      state_d      = ACK;
      prio_d       = 1'b1;
      if_ack_d     = 1'b1;
      bus.mem_addr = bus.if_addr;
      if_rdata_d   = bus.mem_rdata;
    end else if (grant_dm) begin
      state_d      = ACK;
      prio_d       = 1'b0;
      dm_ack_d     = 1'b1;
      bus.mem_addr = bus.dm_addr;
      if (bus.dm_we) begin
        bus.mem_wdata = bus.dm_wdata;
        // a write granted in a reset cycle must never reach the memory
        bus.mem_we    = !reset;
      end else begin
        dm_rdata_d    = bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      prio_q     <= (RR_INIT != 0);
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      if_rdata_q <= {DATA_W{1'b0}};
      dm_rdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.if_ack   = if_ack_q;
  assign bus.dm_ack   = dm_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.dm_rdata = dm_rdata_q;
  assign bus.busy     = (state_q == ACK);

endmodule
